// File: rtl/pc_stall_unit.sv
// Fetch-stage program counter with N-source stall hold counter and buffered redirects.
// Optional macro PC_EXC_EN adds the exc_valid port, which forces pc to EXC_VEC.
module pc_stall_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4,
  parameter int               NUM_STALL = 2,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0180)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_STALL-1:0] stall,
  input  logic                 redirect_valid,
  input  logic [WIDTH-1:0]     redirect_target,
`ifdef PC_EXC_EN
  input  logic                 exc_valid,
`endif
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_seq,
  output logic                 held,
  output logic                 pc_upd
);

  localparam int               CNT_W      = $clog2(NUM_STALL + 1);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [WIDTH-1:0] r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_v;
  logic [WIDTH-1:0] r_pend;
  logic             r_upd;

  logic [WIDTH-1:0] w_pc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_pend_v_next;
  logic [WIDTH-1:0] w_pend_next;
  logic             w_load;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_next;
  logic [CNT_W-1:0] w_k;
  logic             w_exc;
  logic [CNT_W-1:0] w_psum [NUM_STALL+1];

  // Tied low without the feature so the exception branch folds away.
`ifdef PC_EXC_EN
  assign w_exc = exc_valid;
`else
  assign w_exc = 1'b0;
`endif

  assign w_psum[0] = CNT_ZERO;
  generate
    for (genvar gi = 0; gi < NUM_STALL; gi++) begin : g_popcount
      assign w_psum[gi+1] = w_psum[gi] + CNT_W'(stall[gi]);
    end
  endgenerate
  assign w_k = w_psum[NUM_STALL];

  assign pc_seq   = r_pc + STEP_W;
  assign w_target = redirect_target & ALIGN_MASK;
  assign w_next   = r_pend_v ? r_pend : pc_seq;

  always_comb begin
    w_pc_next     = r_pc;
    w_cnt_next    = r_cnt;
    w_pend_v_next = r_pend_v;
    w_pend_next   = r_pend;
    w_load        = 1'b0;
    if (w_exc) begin
      w_pc_next     = EXC_VEC;
      w_cnt_next    = CNT_ZERO;
      w_pend_v_next = 1'b0;
      w_pend_next   = '0;
      w_load        = 1'b1;
    end else if (r_cnt == CNT_ONE || (r_cnt == CNT_ZERO && w_k == CNT_ZERO)) begin
      // Release edge or free-running edge: a live redirect beats the pending one.
      w_pc_next     = redirect_valid ? w_target : w_next;
      w_cnt_next    = CNT_ZERO;
      w_pend_v_next = 1'b0;
      w_pend_next   = '0;
      w_load        = 1'b1;
    end else begin
      w_cnt_next = (r_cnt == CNT_ZERO) ? w_k : (r_cnt - CNT_ONE);
      if (redirect_valid) begin
        w_pend_v_next = 1'b1;
        w_pend_next   = w_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_VEC;
      r_cnt    <= CNT_ZERO;
      r_pend_v <= 1'b0;
      r_pend   <= '0;
      r_upd    <= 1'b0;
    end else begin
      r_pc     <= w_pc_next;
      r_cnt    <= w_cnt_next;
      r_pend_v <= w_pend_v_next;
      r_pend   <= w_pend_next;
      r_upd    <= w_load;
    end
  end

  assign pc     = r_pc;
  assign held   = (r_cnt != CNT_ZERO) || (|stall);
  assign pc_upd = r_upd;

endmodule
